// File: rtl/ks_pkg.sv
// Shared types and helpers for the Kogge-Stone subtractor pipeline.
package ks_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned KsWidth  = 16;
  localparam int unsigned KsLevels = log2(KsWidth);
  localparam int unsigned KsLat    = KsLevels + 1;

endpackage

// File: rtl/black_cell.sv
// Prefix black cell: group generate and propagate.
module black_cell (
  input  logic p_hi_i,
  input  logic g_hi_i,
  input  logic p_lo_i,
  input  logic g_lo_i,
  output logic p_o,
  output logic g_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;
endmodule

// File: rtl/grey_cell.sv
// Prefix grey cell: group generate only.
module grey_cell (
  input  logic p_hi_i,
  input  logic g_hi_i,
  input  logic g_lo_i,
  output logic g_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
endmodule

// File: rtl/ks_prefix_level.sv
// One registered Kogge-Stone prefix level at span Dist, with its stage valid.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIST  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  pg_t  [WIDTH-1:0]       pg_i,
  input  logic [WIDTH-1:0]       psave_i,
  input  logic [2:0]             meta_i,
  output logic                   valid_o,
  output pg_t  [WIDTH-1:0]       pg_o,
  output logic [WIDTH-1:0]       psave_o,
  output logic [2:0]             meta_o
);

  pg_t [WIDTH-1:0] pg_d;
  pg_t [WIDTH-1:0] pg_q;
  logic [WIDTH-1:0] psave_q;
  logic [2:0]       meta_q;
  logic             valid_q;

  // Bits below Dist are already complete; the next Dist bits reach bit 0 and need only g.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign pg_d[i] = pg_i[i];
    end else if (i < 2 * DIST) begin : g_grey
      assign pg_d[i].p = pg_i[i].p;
      grey_cell u_grey (
        .p_hi_i(pg_i[i].p),
        .g_hi_i(pg_i[i].g),
        .g_lo_i(pg_i[i-DIST].g),
        .g_o   (pg_d[i].g)
      );
    end else begin : g_black
      black_cell u_black (
        .p_hi_i(pg_i[i].p),
        .g_hi_i(pg_i[i].g),
        .p_lo_i(pg_i[i-DIST].p),
        .g_lo_i(pg_i[i-DIST].g),
        .p_o   (pg_d[i].p),
        .g_o   (pg_d[i].g)
      );
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pg_q    <= '0;
      psave_q <= '0;
      meta_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        pg_q    <= pg_d;
        psave_q <= psave_i;
        meta_q  <= meta_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign pg_o    = pg_q;
  assign psave_o = psave_q;
  assign meta_o  = meta_q;

endmodule

// File: rtl/ks_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin as a + ~b + ~bin, one register per level.
module ks_sub_pipe
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = KsWidth
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf
);

  localparam int unsigned LEVELS = log2(WIDTH);
  localparam int unsigned LAT    = LEVELS + 1;

  logic           run_q;
  logic [LAT-1:0] vld;
  logic [LAT-1:0] rdy;
  logic           full;
  logic           accept;

  // Stage k may load when some stage at or after it is empty, or the sink drains.
  always_comb begin
    full = 1'b1;
    rdy  = '0;
    for (int k = int'(LAT) - 1; k >= 0; k--) begin
      full   = full & vld[k];
      rdy[k] = ~full | i_ready;
    end
  end

  assign o_ready = run_q & rdy[0];
  assign accept  = i_valid & o_ready;

  // S1: generate/propagate with the carry seed folded into bit 0.
  pg_t [WIDTH-1:0] s1_pg_d, s1_pg_q;
  logic [WIDTH-1:0] s1_ps_q;
  logic [2:0]       s1_meta_q;
  logic             s1_v_q;

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      s1_pg_d[i].p = i_a[i] ^ ~i_b[i];
      s1_pg_d[i].g = i_a[i] & ~i_b[i];
    end
    s1_pg_d[0].g = s1_pg_d[0].g | (s1_pg_d[0].p & ~i_bin);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q     <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_pg_q   <= '0;
      s1_ps_q   <= '0;
      s1_meta_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (rdy[0]) begin
        s1_v_q <= accept;
        if (accept) begin
          s1_pg_q   <= s1_pg_d;
          s1_ps_q   <= i_a ^ ~i_b;
          s1_meta_q <= {i_a[WIDTH-1], i_b[WIDTH-1], ~i_bin};
        end
      end
    end
  end

  pg_t [WIDTH-1:0] st_pg   [LEVELS];
  logic [WIDTH-1:0] st_ps  [LEVELS];
  logic [2:0]       st_meta[LEVELS];

  assign st_pg[0]   = s1_pg_q;
  assign st_ps[0]   = s1_ps_q;
  assign st_meta[0] = s1_meta_q;
  assign vld[0]     = s1_v_q;

  for (genvar j = 0; j < LEVELS - 1; j++) begin : g_lvl
    ks_prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << j)
    ) u_lvl (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .en_i   (rdy[j+1]),
      .valid_i(vld[j]),
      .pg_i   (st_pg[j]),
      .psave_i(st_ps[j]),
      .meta_i (st_meta[j]),
      .valid_o(vld[j+1]),
      .pg_o   (st_pg[j+1]),
      .psave_o(st_ps[j+1]),
      .meta_o (st_meta[j+1])
    );
  end

  // Output stage: last prefix level at span WIDTH/2, then the difference bits.
  pg_t [WIDTH-1:0]    fin_pg;
  logic [WIDTH-1:0]   g_fin;
  logic [WIDTH/2-1:0] unused_p_lo;
  logic [WIDTH-1:0]   diff_d;
  logic               c0;

  assign fin_pg = st_pg[LEVELS-1];
  assign c0     = st_meta[LEVELS-1][0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_fin_bit
    if (i < WIDTH / 2) begin : g_pass
      assign g_fin[i]       = fin_pg[i].g;
      assign unused_p_lo[i] = fin_pg[i].p;
    end else begin : g_grey
      grey_cell u_grey (
        .p_hi_i(fin_pg[i].p),
        .g_hi_i(fin_pg[i].g),
        .g_lo_i(fin_pg[i-WIDTH/2].g),
        .g_o   (g_fin[i])
      );
    end
  end

  assign diff_d = st_ps[LEVELS-1] ^ {g_fin[WIDTH-2:0], c0};

  logic             out_v_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_v_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (rdy[LAT-1]) begin
      out_v_q <= vld[LAT-2];
      if (vld[LAT-2]) begin
        diff_q   <= diff_d;
        borrow_q <= ~g_fin[WIDTH-1];
        ovf_q    <= (st_meta[LEVELS-1][2] ^ st_meta[LEVELS-1][1]) &
                    (diff_d[WIDTH-1] ^ st_meta[LEVELS-1][2]);
      end
    end
  end

  assign vld[LAT-1] = out_v_q;
  assign o_valid    = out_v_q;
  assign o_diff     = diff_q;
  assign o_borrow   = borrow_q;
  assign o_ovf      = ovf_q;

endmodule
